// File: rtl/ram_burst_master_if.sv
// Core-side request/write/response channels plus the RAM pin bundle for ram_burst_master.
// The master modport is the controller's view; slave is the core/RAM side.
interface ram_burst_master_if #(
  parameter int data_length = 32,
  parameter int mem_length  = 32,
  parameter int max_burst   = 8
);
  localparam int AW = $clog2(mem_length);
  localparam int LW = $clog2(max_burst);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [AW-1:0]          req_addr;
  logic [LW-1:0]          req_len;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [data_length-1:0] wr_data;
  logic                   rsp_valid;
  logic [data_length-1:0] rsp_data;
  logic                   rsp_last;
  logic                   done;
  logic                   ram_we;
  logic [AW-1:0]          ram_address;
  logic [data_length-1:0] ram_wdata;
  logic [data_length-1:0] ram_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, ram_rdata,
    output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, done,
           ram_we, ram_address, ram_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, ram_rdata,
    input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, done,
           ram_we, ram_address, ram_wdata
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM (we=0 writes, we=1 reads).
// Read data returns two cycles after issue through a two-stage tag pipeline.
module ram_burst_master #(
  parameter int data_length = 32,
  parameter int mem_length  = 32,
  parameter int max_burst   = 8
) (
  input logic clk,
  input logic rst_n,
  ram_burst_master_if.master bus
);
  localparam int AW = $clog2(mem_length);
  localparam int LW = $clog2(max_burst);
  localparam logic [AW-1:0] LAST_ADDR = AW'(mem_length - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                 state_q;
  logic [AW-1:0]          addr_q;
  logic [LW-1:0]          remain_q;
  logic                   s1_valid_q;
  logic                   s1_last_q;
  logic                   rsp_valid_q;
  logic                   rsp_last_q;
  logic [data_length-1:0] rsp_data_q;
  logic                   done_q;
  logic [AW-1:0]          addr_next_d;
  logic                   wr_beat_s;
  logic                   issue_s;
  logic                   req_ready_s;

  // Wrap explicitly so non-power-of-two RAM depths stay in range.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    next_addr = (a == LAST_ADDR) ? {AW{1'b0}} : a + AW'(1'b1);
  endfunction

  assign addr_next_d = next_addr(addr_q);
  assign wr_beat_s   = (state_q == WRITE) && bus.wr_valid;
  assign issue_s     = (state_q == READ);
  assign req_ready_s = (state_q == IDLE) && !done_q;

  assign bus.req_ready   = req_ready_s;
  assign bus.wr_ready    = (state_q == WRITE);
  assign bus.ram_we      = !wr_beat_s;
  assign bus.ram_address = addr_q;
  assign bus.ram_wdata   = wr_beat_s ? bus.wr_data : {data_length{1'b0}};
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_last    = rsp_last_q;
  assign bus.done        = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= {AW{1'b0}};
      remain_q    <= {LW{1'b0}};
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= {data_length{1'b0}};
      done_q      <= 1'b0;
    end else begin
      // Tags follow each issued beat: stage 1 sees ram_rdata, stage 2 presents it.
      s1_valid_q  <= issue_s;
      s1_last_q   <= issue_s && (remain_q == {LW{1'b0}});
      rsp_valid_q <= s1_valid_q;
      rsp_last_q  <= s1_last_q;
      done_q      <= s1_last_q;
      if (s1_valid_q) begin
        rsp_data_q <= bus.ram_rdata;
      end
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_s) begin
            addr_q   <= bus.req_addr;
            remain_q <= bus.req_len;
            state_q  <= bus.req_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            addr_q   <= addr_next_d;
            remain_q <= remain_q - LW'(1'b1);
            if (remain_q == {LW{1'b0}}) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          addr_q   <= addr_next_d;
          remain_q <= remain_q - LW'(1'b1);
          if (remain_q == {LW{1'b0}}) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (rsp_last_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_burst_master.sv
// Randomised bench for ram_burst_master against a word-array model of the RAM contents.
module tb_ram_burst_master;
  localparam int DL = 32;
  localparam int ML = 32;
  localparam int MB = 8;
  localparam int AW = $clog2(ML);
  localparam int LW = $clog2(MB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  bit [DL-1:0] ram_mem [ML];
  bit [DL-1:0] ref_mem [ML];

  always #5 clk = ~clk;

  ram_burst_master_if #(.data_length(DL), .mem_length(ML), .max_burst(MB)) bus ();

  ram_burst_master #(.data_length(DL), .mem_length(ML), .max_burst(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Single-port synchronous RAM with registered read data.
  always @(posedge clk) begin
    if (!bus.ram_we) ram_mem[bus.ram_address] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_address];
  end

  task automatic start_req(input bit wr, input int addr, input int len);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n >= 50) begin n_bad++; $display("FAIL req_ready_timeout: waited %0d cycles, required <50", n); end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = AW'(addr);
    bus.req_len   = LW'(len);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_addr  = AW'($urandom);
    bus.req_len   = LW'($urandom);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL req_accepted: req_ready=%b required 0", bus.req_ready); end
  endtask

  // mode 0: wr_valid always high, 1: low on alternate cycles starting low, 2: random
  task automatic do_write(input int addr, input int len, input int mode, input int base);
    int beats = 0;
    int cyc = 0;
    int exp_a;
    logic [DL-1:0] d;
    start_req(1'b1, addr, len);
    while (beats < len + 1 && cyc < 100) begin
      case (mode)
        0: bus.wr_valid = 1'b1;
        1: bus.wr_valid = cyc[0];
        default: bus.wr_valid = 1'($urandom_range(0, 1));
      endcase
      d = (base != 0) ? DL'(base + beats) : DL'($urandom);
      bus.wr_data = d;
      #1;
      exp_a = (addr + beats) % ML;
      n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %b required 1", bus.wr_ready); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL wr_done_early: got %b required 0", bus.done); end
      if (bus.wr_valid) begin
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_bad++; $display("FAIL wr_we: got %b required 0", bus.ram_we); end
        n_cmp++; if (bus.ram_address !== AW'(exp_a)) begin n_bad++; $display("FAIL wr_addr: got %0d required %0d", bus.ram_address, exp_a); end
        n_cmp++; if (bus.ram_wdata !== d) begin n_bad++; $display("FAIL wr_wdata: got %h required %h", bus.ram_wdata, d); end
        ref_mem[exp_a] = d;
        beats++;
      end else begin
        n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL wr_gap_we: got %b required 1", bus.ram_we); end
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc >= 100) begin n_bad++; $display("FAIL wr_timeout: %0d beats after %0d cycles, required %0d", beats, cyc, len + 1); end
    bus.wr_valid = 1'b0;
    #1;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL wr_done: got %b required 1", bus.done); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready_on_done: got %b required 0", bus.req_ready); end
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready_after: got %b required 0", bus.wr_ready); end
    n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL wr_we_after: got %b required 1", bus.ram_we); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL wr_done_once: got %b required 0", bus.done); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_idle_ready: got %b required 1", bus.req_ready); end
  endtask

  // With hold set, a competing request (haddr/hlen) is presented throughout the burst.
  task automatic do_read(input int addr, input int len, input bit hold, input int haddr, input int hlen);
    bit exp_v;
    int i;
    start_req(1'b0, addr, len);
    if (hold) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = AW'(haddr);
      bus.req_len   = LW'(hlen);
    end
    for (int c = 0; c <= len + 3; c++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      #1;
      exp_v = (c >= 2) && (c <= len + 2);
      i = c - 2;
      n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL rd_we: cycle %0d got %b required 1", c, bus.ram_we); end
      if (c <= len) begin
        n_cmp++; if (bus.ram_address !== AW'((addr + c) % ML)) begin n_bad++; $display("FAIL rd_addr: cycle %0d got %0d required %0d", c, bus.ram_address, (addr + c) % ML); end
      end
      n_cmp++; if (bus.rsp_valid !== exp_v) begin n_bad++; $display("FAIL rd_valid: cycle %0d got %b required %b", c, bus.rsp_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus.rsp_data !== ref_mem[(addr + i) % ML]) begin n_bad++; $display("FAIL rd_data: beat %0d got %h required %h", i, bus.rsp_data, ref_mem[(addr + i) % ML]); end
        n_cmp++; if (bus.rsp_last !== (i == len)) begin n_bad++; $display("FAIL rd_last: beat %0d got %b required %b", i, bus.rsp_last, i == len); end
      end
      n_cmp++; if (bus.done !== (exp_v && i == len)) begin n_bad++; $display("FAIL rd_done: cycle %0d got %b required %b", c, bus.done, exp_v && i == len); end
      n_cmp++; if (bus.req_ready !== (c == len + 3)) begin n_bad++; $display("FAIL rd_req_ready: cycle %0d got %b required %b", c, bus.req_ready, c == len + 3); end
      if (c < len + 3) @(negedge clk);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b required 1", bus.req_ready); end
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ready: got %b required 0", bus.wr_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== '0) begin n_bad++; $display("FAIL rst_rsp_data: got %h required 0", bus.rsp_data); end
    n_cmp++; if (bus.rsp_last !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_last: got %b required 0", bus.rsp_last); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b required 0", bus.done); end
    n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL rst_ram_we: got %b required 1", bus.ram_we); end
    n_cmp++; if (bus.ram_address !== '0) begin n_bad++; $display("FAIL rst_ram_address: got %0d required 0", bus.ram_address); end
    n_cmp++; if (bus.ram_wdata !== '0) begin n_bad++; $display("FAIL rst_ram_wdata: got %h required 0", bus.ram_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    start_req(1'b0, 8, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_req_ready: got %b required 1", bus.req_ready); end
    n_cmp++; if (bus.ram_address !== '0) begin n_bad++; $display("FAIL abort_addr: got %0d required 0", bus.ram_address); end
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_rsp_valid: cycle %0d got %b required 0", c, bus.rsp_valid); end
      n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL abort_we: cycle %0d got %b required 1", c, bus.ram_we); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done: cycle %0d got %b required 0", c, bus.done); end
      @(negedge clk);
    end
  endtask

  task automatic test_write_burst();
    do_write(2, 3, 0, 'hA0);
  endtask

  task automatic test_read_burst();
    do_read(2, 3, 1'b0, 0, 0);
  endtask

  task automatic test_wrap();
    do_write(30, 3, 0, 'hB0);
    do_read(30, 3, 1'b0, 0, 0);
  endtask

  task automatic test_write_gaps();
    do_write(12, 2, 1, 'hC0);
    do_read(12, 2, 1'b0, 0, 0);
  endtask

  task automatic test_single_and_max();
    do_write(7, 0, 0, 'hD0);
    do_read(7, 0, 1'b0, 0, 0);
    do_write(20, MB - 1, 2, 0);
    do_read(20, MB - 1, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_read(2, 3, 1'b1, 20, 1);
    do_read(20, 1, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      do_write($urandom_range(0, ML - 1), $urandom_range(0, MB - 1), 2, 0);
      do_read($urandom_range(0, ML - 1), $urandom_range(0, MB - 1), 1'b0, 0, 0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_write_gaps();
    test_single_and_max();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    do_read(2, 3, 1'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator-side controller for the single-port synchronous RAM used in the MiniMicro memory subsystem.
- Accepts single or burst read/write requests from a core-side valid/ready handshake.
- Sequences the RAM control, address and data lines, with we = 0 to write and we = 1 to read.
- Collects the registered read data and returns it as a response stream, flagging the last beat.

Parameters:
data_length, 32, data word width in bits
mem_length, 32, number of RAM words; address width AW = $clog2(mem_length)
max_burst, 8, maximum beats per request; length field width LW = $clog2(max_burst)

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  AW  start word address
req_len  input  LW  beats minus one (0 = single beat)
wr_valid  input  1  write beat data present
wr_ready  output  1  controller consumes write beat this cycle
wr_data  input  data_length  write beat data
rsp_valid  output  1  read beat data valid
rsp_data  output  data_length  read beat data
rsp_last  output  1  final beat of read burst (qualified by rsp_valid)
done  output  1  one-cycle pulse on burst completion
ram_we  output  1  to RAM: 0 = write, 1 = read
ram_address  output  AW  to RAM address bus
ram_wdata  output  data_length  to RAM write data
ram_rdata  input  data_length  from RAM registered read data

Behaviour:
- States: IDLE, WRITE, READ, DRAIN.
- Reset (rst_n low at posedge): state = IDLE; beat counter and address = 0; in-flight read tags cleared.
  - Outputs after reset: req_ready = 1, wr_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_last = 0, done = 0, ram_we = 1, ram_address = 0, ram_wdata = 0.
- Reset mid-burst aborts the burst. No further RAM writes and no rsp_valid for aborted reads.
- ram_we is 1 in every cycle except an accepted write beat. IDLE, READ and DRAIN never write the RAM.
- req_ready = 1 only in IDLE. Handshake occurs when req_valid && req_ready.
  - On handshake, latch addr = req_addr, remaining = req_len, and go to WRITE or READ per req_write.
  - req_* inputs are ignored while req_ready = 0.
- WRITE:
  - wr_ready = 1 throughout the state.
  - Each cycle with wr_valid = 1: ram_we = 0, ram_address = addr, ram_wdata = wr_data (combinational in the same cycle).
  - On each such beat, addr advances and remaining decrements.
  - A wr_valid = 0 cycle stalls with no write and no advance.
  - After the last beat: done = 1 in the next cycle and state = IDLE.
- READ:
  - One beat is issued per cycle (ram_we = 1, ram_address = addr). There is no stall and no response backpressure.
  - After the last issue: state = DRAIN.
- Read latency:
  - A beat issued in cycle N is captured into rsp_data from ram_rdata at the end of cycle N+1.
  - rsp_valid = 1 in cycle N+2.
  - Beats return in order, one per cycle, with no gaps.
- DRAIN: wait until the final beat is returned.
  - rsp_last = 1 and done = 1 in the same cycle as the final rsp_valid.
  - State = IDLE in the following cycle.
- Address increment:
  - addr = addr + 1, except addr = mem_length-1 wraps to 0.
  - The wrap holds for non-power-of-two mem_length.
- Beat count is req_len + 1, with req_len in 0..max_burst-1.
- A new request is not accepted in the same cycle done pulses. Earliest acceptance is the cycle after.
- rsp_data holds its last value when rsp_valid = 0.

Test Plan:
- Write burst, req_addr = 2, req_len = 3, wr_data = 0xA0..0xA3 with wr_valid held high -> ram_we = 0 on 4 consecutive cycles at addresses 2, 3, 4, 5; done pulses once; req_ready returns to 1.
- Read burst, req_addr = 2, req_len = 3 after the previous write -> rsp_valid on 4 consecutive cycles starting 2 cycles after the first issue, rsp_data = 0xA0..0xA3, rsp_last and done only on 0xA3.
- Write burst, req_addr = 30, req_len = 3 with mem_length = 32, then read back -> addresses 30, 31, 0, 1; data matches.
- Write, req_len = 2, with wr_valid low on alternate cycles -> exactly 3 RAM writes, addresses advance only on wr_valid cycles, ram_we = 1 during gaps.
- req_valid held high during a read burst with different req_addr -> ignored until req_ready = 1; second request starts at its own address.
- rst_n low for 1 cycle during the 2nd beat of a 4-beat read -> next cycle IDLE, req_ready = 1, ram_we = 1; no rsp_valid afterwards.
